// File: rtl/seven_segment_editor.sv
// -----------------------------------------------------------------------------
// seven_segment_editor
//
// Front-panel editor for an N-digit hex seven-segment display. Five debounced
// button levels are turned into a cursor position, a decimal-point mask and
// an editable hex value. There are two modes:
//   NAVIGATE - up/down toggle the decimal point under the cursor.
//   EDIT     - up/down step the nibble under the cursor, with hold-to-repeat,
//              and the digit under the cursor blinks.
// Left/right move the cursor in both modes. Center toggles the mode.
//
// Ports:
//   clock, resetN            clock, asynchronous active-low reset
//   buttonLeft/Right/Up/Down/Center
//                            debounced button levels, synchronous to clock
//   load, loadData           one-cycle strobe that overwrites the value
//   data                     edited value, nibble i drives digit i (0 = right)
//   pointEnable              decimal-point mask
//   digitBlank               per-digit blank request (cursor blink)
//   cursor, cursorOneHot     selected digit index and its one-hot decode
//   editMode                 0 = NAVIGATE, 1 = EDIT
// -----------------------------------------------------------------------------
module seven_segment_editor #(
    parameter int NUM_DIGITS    = 4,
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int BLINK_CYCLES  = 12_500_000,
    localparam int CW           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clock,
    input  logic                    resetN,
    input  logic                    buttonLeft,
    input  logic                    buttonRight,
    input  logic                    buttonUp,
    input  logic                    buttonDown,
    input  logic                    buttonCenter,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] loadData,
    output logic [4*NUM_DIGITS-1:0] data,
    output logic [NUM_DIGITS-1:0]   pointEnable,
    output logic [NUM_DIGITS-1:0]   digitBlank,
    output logic [CW-1:0]           cursor,
    output logic [NUM_DIGITS-1:0]   cursorOneHot,
    output logic                    editMode
);

    typedef enum logic {
        NAVIGATE = 1'b0,
        EDIT     = 1'b1
    } mode_e;

    // Repeat counter only has to reach the larger of the two intervals minus one.
    localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RCW     = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam int BCW     = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [CW-1:0]  CUR_LAST   = CW'(NUM_DIGITS - 1);
    localparam logic [RCW-1:0] HOLD_LAST  = RCW'(HOLD_CYCLES - 1);
    localparam logic [RCW-1:0] REP_LAST   = RCW'(REPEAT_CYCLES - 1);
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_CYCLES - 1);

    // Button vector order: {center, down, up, right, left}
    localparam int B_LEFT   = 0;
    localparam int B_RIGHT  = 1;
    localparam int B_UP     = 2;
    localparam int B_DOWN   = 3;
    localparam int B_CENTER = 4;

    mode_e                   mode_q, mode_d;
    logic [CW-1:0]           cursor_q, cursor_d;
    logic [4*NUM_DIGITS-1:0] data_q, data_d;
    logic [NUM_DIGITS-1:0]   point_q, point_d;
    logic [4:0]              btn_prev_q, btn_prev_d;
    logic [RCW-1:0]          rpt_cnt_q, rpt_cnt_d;
    logic                    rpt_run_q, rpt_run_d;   // 0: waiting for first repeat, 1: repeating
    logic [BCW-1:0]          blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;

    logic [4:0]            btn;
    logic [4:0]            ev;
    logic                  rpt_clear;
    logic                  rpt_fire;
    logic                  step_up;
    logic                  step_down;
    logic [NUM_DIGITS-1:0] one_hot;

    assign btn = {buttonCenter, buttonDown, buttonUp, buttonRight, buttonLeft};
    assign ev  = btn & ~btn_prev_q;

    // NOTE: every signal assigned in always_comb gets a default at the top so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        mode_d        = mode_q;
        cursor_d      = cursor_q;
        data_d        = data_q;
        point_d       = point_q;
        btn_prev_d    = btn;
        rpt_cnt_d     = rpt_cnt_q;
        rpt_run_d     = rpt_run_q;
        rpt_fire      = 1'b0;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        step_up       = 1'b0;
        step_down     = 1'b0;

        // Mode toggle.
        if (ev[B_CENTER]) begin
            mode_d = (mode_q == EDIT) ? NAVIGATE : EDIT;
        end

        // Cursor: left wins over right; wrap is modulo NUM_DIGITS.
        if (ev[B_LEFT]) begin
            cursor_d = (cursor_q == CUR_LAST) ? '0 : cursor_q + 1'b1;
        end else if (ev[B_RIGHT]) begin
            cursor_d = (cursor_q == '0) ? CUR_LAST : cursor_q - 1'b1;
        end

        // Auto-repeat tracks up when up is held, otherwise down. Any change of
        // the up level covers both an up press and a switch of tracked key.
        rpt_clear = (mode_q != EDIT)
                  || !(buttonUp || buttonDown)
                  || (buttonUp != btn_prev_q[B_UP])
                  || (ev[B_DOWN] && !buttonUp);

        if (rpt_clear) begin
            rpt_cnt_d = '0;
            rpt_run_d = 1'b0;
        end else if (rpt_run_q ? (rpt_cnt_q == REP_LAST) : (rpt_cnt_q == HOLD_LAST)) begin
            rpt_fire  = 1'b1;
            rpt_cnt_d = '0;
            rpt_run_d = 1'b1;
        end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
        end

        step_up   = ev[B_UP]   || (rpt_fire && buttonUp);
        step_down = ev[B_DOWN] || (rpt_fire && !buttonUp);

        // Value and point actions use the mode and cursor held before the edge.
        if (load) begin
            data_d = loadData;
        end else if (mode_q == EDIT) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cursor_q == CW'(i)) begin
                    if (step_up) begin
                        data_d[4*i +: 4] = data_q[4*i +: 4] + 4'd1;
                    end else if (step_down) begin
                        data_d[4*i +: 4] = data_q[4*i +: 4] - 4'd1;
                    end
                end
            end
        end

        if ((mode_q == NAVIGATE) && (ev[B_UP] || ev[B_DOWN])) begin
            point_d[cursor_q] = ~point_q[cursor_q];
        end

        // Blink restarts visible whenever EDIT is entered or the cursor moves,
        // and is parked at zero outside EDIT.
        if ((mode_d != EDIT) || (mode_q != EDIT) || ev[B_LEFT] || ev[B_RIGHT]) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d   = blink_cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            mode_q        <= NAVIGATE;
            cursor_q      <= '0;
            data_q        <= '0;
            point_q       <= '0;
            btn_prev_q    <= '0;
            rpt_cnt_q     <= '0;
            rpt_run_q     <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            cursor_q      <= cursor_d;
            data_q        <= data_d;
            point_q       <= point_d;
            btn_prev_q    <= btn_prev_d;
            rpt_cnt_q     <= rpt_cnt_d;
            rpt_run_q     <= rpt_run_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign one_hot      = NUM_DIGITS'(1) << cursor_q;
    assign data         = data_q;
    assign pointEnable  = point_q;
    assign cursor       = cursor_q;
    assign cursorOneHot = one_hot;
    assign digitBlank   = blink_phase_q ? one_hot : '0;
    assign editMode     = (mode_q == EDIT);

endmodule

// File: tb/tb_seven_segment_editor.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_editor
//
// Directed table, hand-written corner sequences and a randomized run, all
// compared against a behavioural model of the editor kept in this file.
// -----------------------------------------------------------------------------
module tb_seven_segment_editor;

    localparam int N     = 4;
    localparam int HOLD  = 8;
    localparam int REP   = 3;
    localparam int BLINK = 4;

    localparam logic [4:0] B_0 = 5'b00000;
    localparam logic [4:0] B_L = 5'b00001;
    localparam logic [4:0] B_R = 5'b00010;
    localparam logic [4:0] B_U = 5'b00100;
    localparam logic [4:0] B_D = 5'b01000;
    localparam logic [4:0] B_C = 5'b10000;

    logic          clock = 1'b0;
    logic          resetN = 1'b0;
    logic          buttonLeft = 1'b0, buttonRight = 1'b0, buttonUp = 1'b0;
    logic          buttonDown = 1'b0, buttonCenter = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   loadData = '0;
    logic [15:0]   data;
    logic [3:0]    pointEnable;
    logic [3:0]    digitBlank;
    logic [1:0]    cursor;
    logic [3:0]    cursorOneHot;
    logic          editMode;

    seven_segment_editor #(
        .NUM_DIGITS    (N),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .BLINK_CYCLES  (BLINK)
    ) dut (
        .clock        (clock),
        .resetN       (resetN),
        .buttonLeft   (buttonLeft),
        .buttonRight  (buttonRight),
        .buttonUp     (buttonUp),
        .buttonDown   (buttonDown),
        .buttonCenter (buttonCenter),
        .load         (load),
        .loadData     (loadData),
        .data         (data),
        .pointEnable  (pointEnable),
        .digitBlank   (digitBlank),
        .cursor       (cursor),
        .cursorOneHot (cursorOneHot),
        .editMode     (editMode)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int         m_mode;        // 0 navigate, 1 edit
    int         m_cur;
    logic [3:0] m_dig [N];
    bit         m_pt  [N];
    bit         m_prev[5];
    int         m_held;        // edges since the tracked key was pressed
    int         m_age;         // edges since blink restart

    task automatic model_reset();
        m_mode = 0; m_cur = 0; m_held = 0; m_age = 0;
        for (int i = 0; i < N; i++) begin m_dig[i] = '0; m_pt[i] = 0; end
        for (int i = 0; i < 5; i++) m_prev[i] = 0;
    endtask

    task automatic model_step(input logic [4:0] b, input logic ld, input logic [15:0] ldv);
        bit ev[5];
        int old_mode = m_mode;
        int old_cur  = m_cur;
        bit fire = 0;
        bit up_act, dn_act, moved;
        for (int i = 0; i < 5; i++) ev[i] = b[i] && !m_prev[i];
        if (ev[4]) m_mode = 1 - m_mode;
        moved = ev[0] || ev[1];
        if (ev[0]) m_cur = (old_cur + 1) % N;
        else if (ev[1]) m_cur = (old_cur + N - 1) % N;
        // Hold-to-repeat: fires at press+HOLD, then every REP.
        if (old_mode == 1 && (b[2] || b[3])) begin
            if ((b[2] != m_prev[2]) || (ev[3] && !b[2])) m_held = 0;
            else begin
                m_held++;
                fire = (m_held >= HOLD) && (((m_held - HOLD) % REP) == 0);
            end
        end else m_held = 0;
        up_act = ev[2] || (fire && b[2]);
        dn_act = ev[3] || (fire && !b[2]);
        if (old_mode == 1) begin
            if (!ld) begin
                if (up_act) m_dig[old_cur] = m_dig[old_cur] + 4'd1;
                else if (dn_act) m_dig[old_cur] = m_dig[old_cur] - 4'd1;
            end
        end else if (ev[2] || ev[3]) m_pt[old_cur] = !m_pt[old_cur];
        if (ld) for (int i = 0; i < N; i++) m_dig[i] = ldv[4*i +: 4];
        if (m_mode != 1 || old_mode != 1 || moved) m_age = 0;
        else m_age++;
        for (int i = 0; i < 5; i++) m_prev[i] = b[i];
    endtask

    task automatic compare_all(input string name);
        logic [15:0] ed;
        logic [3:0]  ep, eb, eo;
        for (int i = 0; i < N; i++) begin
            ed[4*i +: 4] = m_dig[i];
            ep[i] = m_pt[i];
        end
        eo = 4'(1 << m_cur);
        eb = (m_mode == 1 && ((m_age / BLINK) % 2) == 1) ? eo : 4'h0;
        check(name,
              32'({data, pointEnable, digitBlank, cursor, cursorOneHot, editMode}),
              32'({ed, ep, eb, 2'(m_cur), eo, 1'(m_mode)}));
    endtask

    task automatic cycle(input logic [4:0] b, input logic ld, input logic [15:0] ldv,
                         input string name);
        {buttonCenter, buttonDown, buttonUp, buttonRight, buttonLeft} = b;
        load = ld;
        loadData = ldv;
        @(posedge clock);
        model_step(b, ld, ldv);
        #1;
        compare_all(name);
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic [4:0] btn;
        logic [1:0] cur;
        logic [3:0] pt;
    } vec_t;

    vec_t tbl [20];

    logic [4:0]  rb;
    logic        rld;
    logic [15:0] rldv;
    logic [3:0]  exp_nib;

    initial begin
        tbl = '{
            '{B_L, 2'd1, 4'h0}, '{B_0, 2'd1, 4'h0},
            '{B_L, 2'd2, 4'h0}, '{B_0, 2'd2, 4'h0},
            '{B_L, 2'd3, 4'h0}, '{B_0, 2'd3, 4'h0},
            '{B_L, 2'd0, 4'h0}, '{B_0, 2'd0, 4'h0},
            '{B_L, 2'd1, 4'h0}, '{B_0, 2'd1, 4'h0},
            '{B_R, 2'd0, 4'h0}, '{B_0, 2'd0, 4'h0},
            '{B_R, 2'd3, 4'h0}, '{B_0, 2'd3, 4'h0},
            '{B_R, 2'd2, 4'h0}, '{B_0, 2'd2, 4'h0},
            '{B_U, 2'd2, 4'h4}, '{B_0, 2'd2, 4'h4},
            '{B_D, 2'd2, 4'h0}, '{B_0, 2'd2, 4'h0}
        };

        // Reset state.
        #12;
        check("reset_state",
              32'({data, pointEnable, digitBlank, cursor, cursorOneHot, editMode}),
              32'({16'h0, 4'h0, 4'h0, 2'd0, 4'b0001, 1'b0}));
        model_reset();
        @(negedge clock);
        resetN = 1'b1;

        // Cursor walk and point toggles.
        for (int i = 0; i < $size(tbl); i++) begin
            cycle(tbl[i].btn, 1'b0, 16'h0, "table");
            check("table_cursor", 32'(cursor), 32'(tbl[i].cur));
            check("table_point", 32'(pointEnable), 32'(tbl[i].pt));
        end

        // Long hold of up in NAVIGATE toggles only once.
        for (int i = 0; i < 50; i++) cycle(B_U, 1'b0, 16'h0, "nav_hold");
        check("nav_hold_point", 32'(pointEnable), 32'h4);
        cycle(B_0, 1'b0, 16'h0, "nav_release");

        // Repeat timing: cursor 0, nibble E, EDIT.
        cycle(B_0, 1'b1, 16'h000E, "prep_load");
        cycle(B_L, 1'b0, 16'h0, "prep");
        cycle(B_0, 1'b0, 16'h0, "prep");
        cycle(B_L, 1'b0, 16'h0, "prep");
        cycle(B_0, 1'b0, 16'h0, "prep");
        cycle(B_C, 1'b0, 16'h0, "enter_edit");
        check("edit_mode", 32'(editMode), 32'd1);
        cycle(B_0, 1'b0, 16'h0, "prep");
        for (int j = 0; j < 12; j++) begin
            cycle(B_U, 1'b0, 16'h0, "repeat");
            exp_nib = (j < HOLD) ? 4'hF : ((j < HOLD + REP) ? 4'h0 : 4'h1);
            check("repeat_nibble", 32'(data), 32'({12'h000, exp_nib}));
        end
        for (int j = 0; j < 7; j++) cycle(B_0, 1'b0, 16'h0, "repeat_release");
        check("repeat_release_data", 32'(data), 32'h0001);

        // Blink: enter EDIT at e with cursor 1.
        cycle(B_C, 1'b0, 16'h0, "blink_prep");
        cycle(B_0, 1'b0, 16'h0, "blink_prep");
        cycle(B_L, 1'b0, 16'h0, "blink_prep");
        cycle(B_0, 1'b0, 16'h0, "blink_prep");
        cycle(B_C, 1'b0, 16'h0, "blink_e");
        check("blink_e", 32'(digitBlank), 32'h0);
        for (int j = 1; j < BLINK; j++) begin
            cycle(B_0, 1'b0, 16'h0, "blink_vis");
            check("blink_visible", 32'(digitBlank), 32'h0);
        end
        cycle(B_0, 1'b0, 16'h0, "blink_on");
        check("blink_blank", 32'(digitBlank), 32'b0010);
        cycle(B_L, 1'b0, 16'h0, "blink_move");
        check("blink_move_blank", 32'(digitBlank), 32'h0);
        check("blink_move_onehot", 32'(cursorOneHot), 32'b0100);

        // Load beats up; center leaves EDIT in the same cycle.
        cycle(B_U | B_C, 1'b1, 16'h1234, "load_up_center");
        check("load_data", 32'(data), 32'h1234);
        check("load_mode", 32'(editMode), 32'd0);

        // Asynchronous reset during auto-repeat.
        cycle(B_0, 1'b0, 16'h0, "rst_prep");
        cycle(B_C, 1'b0, 16'h0, "rst_prep");
        for (int j = 0; j < 10; j++) cycle(B_U, 1'b0, 16'h0, "rst_hold");
        #3;
        resetN = 1'b0;
        #1;
        check("async_reset",
              32'({data, pointEnable, digitBlank, cursor, cursorOneHot, editMode}),
              32'({16'h0, 4'h0, 4'h0, 2'd0, 4'b0001, 1'b0}));
        model_reset();
        @(posedge clock);
        #1;
        check("reset_held",
              32'({data, pointEnable, digitBlank, cursor, cursorOneHot, editMode}),
              32'({16'h0, 4'h0, 4'h0, 2'd0, 4'b0001, 1'b0}));
        @(negedge clock);
        resetN = 1'b1;
        cycle(B_U, 1'b0, 16'h0, "post_reset_up");
        check("post_reset_point", 32'(pointEnable), 32'b0001);
        check("post_reset_mode", 32'(editMode), 32'd0);

        // Randomized run against the model.
        rb = B_U;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 5)  == 0) rb[0] = ~rb[0];
            if ($urandom_range(0, 5)  == 0) rb[1] = ~rb[1];
            if ($urandom_range(0, 11) == 0) rb[2] = ~rb[2];
            if ($urandom_range(0, 11) == 0) rb[3] = ~rb[3];
            if ($urandom_range(0, 19) == 0) rb[4] = ~rb[4];
            rld  = ($urandom_range(0, 39) == 0);
            rldv = 16'($urandom);
            cycle(rb, rld, rldv, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
